receive_slot_array: RTL and testbench

//  Multi-slot UDP/IPv4 receive buffer for a virtual port; successor to the single-slot receiver.

---
 rtl/receive_slot_array.sv | 327 ++++++++++++++++++++++++++++++++
 tb/tb_receive_slot_array.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/receive_slot_array.sv
// Multi-slot UDP/IPv4 receive buffer: packets fill round-robin slots, commit in order,
// and drain over a valid/ready stream through a 2-entry output buffer.
module receive_slot_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SLOT_COUNT = 4,
  parameter int unsigned SLOT_DEPTH = 1024,
  localparam int unsigned LEN_W = $clog2(SLOT_DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_enable,
  input  logic                  good_packet,
  input  logic                  bad_packet,
  input  logic [15:0]           ipv4_flags,
  input  logic [15:0]           ipv4_identification,
  input  logic                  push_data_ready,
  output logic                  ready,
  output logic                  data_ready,
  output logic [15:0]           current_ipv4_flags,
  output logic [15:0]           current_ipv4_identification,
  output logic [LEN_W-1:0]      current_length,
  output logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_data_valid,
  output logic                  push_data_last,
  output logic [15:0]           dropped_count
);

  localparam int unsigned SW = $clog2(SLOT_COUNT);
  localparam int unsigned OW = $clog2(SLOT_DEPTH);
  localparam int unsigned AW = SW + OW;

  typedef enum logic [1:0] {SlotFree, SlotFilling, SlotCommitted, SlotDraining} slot_state_e;
  typedef enum logic [1:0] {WIdle, WFill, WDrop} wr_state_e;
  typedef enum logic {RIdle, RDrain} rd_state_e;

  slot_state_e      slot_q     [SLOT_COUNT];
  slot_state_e      slot_d     [SLOT_COUNT];
  logic [15:0]      tag_flags_q[SLOT_COUNT];
  logic [15:0]      tag_id_q   [SLOT_COUNT];
  logic [LEN_W-1:0] slot_len_q [SLOT_COUNT];

  logic [DATA_WIDTH-1:0] mem [SLOT_COUNT*SLOT_DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata_q;

  wr_state_e        wr_state_q, wr_state_d;
  logic [SW-1:0]    wr_slot_q, wr_slot_d;
  logic [LEN_W-1:0] wr_len_q, wr_len_d;
  logic             wr_claimed_q, wr_claimed_d;
  logic [SW-1:0]    alloc_ptr_q;

  rd_state_e        rd_state_q, rd_state_d;
  logic [SW-1:0]    rd_slot_q, rd_slot_d;
  logic [LEN_W-1:0] rd_off_q, rd_off_d;
  logic [LEN_W-1:0] rd_len_q, rd_len_d;
  logic             rd_vld_q, rd_last_q;

  logic [SW-1:0]    cq_q [SLOT_COUNT];
  logic [SW:0]      cq_wr_q, cq_rd_q;
  logic             cq_empty;
  logic [SW-1:0]    cq_head;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic                  buf_last_q [2];
  logic                  buf_wr_q, buf_rd_q;
  logic [1:0]            buf_cnt_q;

  logic             ready_q, data_ready_q;
  logic [15:0]      cur_flags_q, cur_id_q, dropped_q;
  logic [LEN_W-1:0] cur_len_q;

  logic             free_found;
  logic [SW-1:0]    free_idx, cand;
  logic             claim, commit, release_wr, drop;
  logic [SW-1:0]    commit_idx;
  logic [LEN_W-1:0] commit_len;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr, rd_raddr;
  logic             rd_issue, rd_issue_last, rd_start;
  logic             pop, last_xfer, space;
  logic [2:0]       occ;
  logic             head_valid, any_free, any_busy;
  logic [SW-1:0]    head_sel;

  assign cq_empty  = (cq_wr_q == cq_rd_q);
  assign cq_head   = cq_q[cq_rd_q[SW-1:0]];
  assign pop       = push_data_valid && push_data_ready;
  assign last_xfer = pop && buf_last_q[buf_rd_q];
  // Occupancy after this cycle's pop, counting the beat already in flight from storage.
  assign occ       = {1'b0, buf_cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign space     = (occ < 3'd2);

  always_comb begin
    free_found = 1'b0;
    free_idx   = alloc_ptr_q;
    cand       = '0;
    for (int i = 0; i < int'(SLOT_COUNT); i++) begin
      cand = alloc_ptr_q + SW'(i);
      if (!free_found && slot_q[cand] == SlotFree) begin
        free_found = 1'b1;
        free_idx   = cand;
      end
    end
  end

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_slot_d    = wr_slot_q;
    wr_len_d     = wr_len_q;
    wr_claimed_d = wr_claimed_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    claim        = 1'b0;
    commit       = 1'b0;
    commit_idx   = wr_slot_q;
    commit_len   = wr_len_q;
    release_wr   = 1'b0;
    drop         = 1'b0;
    unique case (wr_state_q)
      WIdle: begin
        if (data_enable && !bad_packet) begin
          if (free_found) begin
            claim        = 1'b1;
            mem_we       = 1'b1;
            mem_waddr    = {free_idx, {OW{1'b0}}};
            wr_slot_d    = free_idx;
            wr_len_d     = LEN_W'(1);
            wr_claimed_d = 1'b1;
            if (good_packet) begin
              commit     = 1'b1;
              commit_idx = free_idx;
              commit_len = LEN_W'(1);
            end else begin
              wr_state_d = WFill;
            end
          end else if (good_packet) begin
            drop = 1'b1;
          end else begin
            wr_claimed_d = 1'b0;
            wr_state_d   = WDrop;
          end
        end
      end
      WFill: begin
        if (data_enable && wr_len_q == LEN_W'(SLOT_DEPTH)) begin
          // Overflow beat: keep the slot until the packet ends, then release it.
          if (bad_packet || good_packet) begin
            release_wr = 1'b1;
            drop       = !bad_packet;
            wr_state_d = WIdle;
          end else begin
            wr_state_d = WDrop;
          end
        end else begin
          if (data_enable) begin
            mem_we    = 1'b1;
            mem_waddr = {wr_slot_q, wr_len_q[OW-1:0]};
            wr_len_d  = wr_len_q + LEN_W'(1);
          end
          if (bad_packet) begin
            release_wr = 1'b1;
            wr_state_d = WIdle;
          end else if (good_packet) begin
            commit     = 1'b1;
            commit_len = wr_len_d;
            wr_state_d = WIdle;
          end
        end
      end
      WDrop: begin
        if (bad_packet || good_packet) begin
          release_wr = wr_claimed_q;
          drop       = !bad_packet;
          wr_state_d = WIdle;
        end
      end
      default: wr_state_d = WIdle;
    endcase
  end

  always_comb begin
    rd_state_d    = rd_state_q;
    rd_slot_d     = rd_slot_q;
    rd_off_d      = rd_off_q;
    rd_len_d      = rd_len_q;
    rd_issue      = 1'b0;
    rd_issue_last = 1'b0;
    rd_raddr      = '0;
    rd_start      = 1'b0;
    unique case (rd_state_q)
      RIdle: begin
        // Fetch beat 0 in the same cycle the head is taken to cut first-beat latency.
        if (!cq_empty && space) begin
          rd_start      = 1'b1;
          rd_issue      = 1'b1;
          rd_raddr      = {cq_head, {OW{1'b0}}};
          rd_issue_last = (slot_len_q[cq_head] == LEN_W'(1));
          rd_slot_d     = cq_head;
          rd_off_d      = LEN_W'(1);
          rd_len_d      = slot_len_q[cq_head];
          rd_state_d    = RDrain;
        end
      end
      RDrain: begin
        if (rd_off_q != rd_len_q && space) begin
          rd_issue      = 1'b1;
          rd_raddr      = {rd_slot_q, rd_off_q[OW-1:0]};
          rd_issue_last = (rd_off_q == rd_len_q - LEN_W'(1));
          rd_off_d      = rd_off_q + LEN_W'(1);
        end
        if (last_xfer) rd_state_d = RIdle;
      end
      default: rd_state_d = RIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < int'(SLOT_COUNT); i++) slot_d[i] = slot_q[i];
    if (claim)      slot_d[free_idx]   = SlotFilling;
    if (commit)     slot_d[commit_idx] = SlotCommitted;
    if (release_wr) slot_d[wr_slot_q]  = SlotFree;
    if (rd_start)   slot_d[cq_head]    = SlotDraining;
    if (last_xfer)  slot_d[rd_slot_q]  = SlotFree;
  end

  always_comb begin
    any_free = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < int'(SLOT_COUNT); i++) begin
      if (slot_q[i] == SlotFree) any_free = 1'b1;
      if (slot_q[i] == SlotCommitted || slot_q[i] == SlotDraining) any_busy = 1'b1;
    end
  end

  assign head_valid = (rd_state_q == RDrain) || !cq_empty;
  assign head_sel   = (rd_state_q == RDrain) ? rd_slot_q : cq_head;

  always_ff @(posedge clock) begin
    if (mem_we)   mem[mem_waddr] <= data;
    if (rd_issue) mem_rdata_q    <= mem[rd_raddr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q   <= WIdle;
      wr_slot_q    <= '0;
      wr_len_q     <= '0;
      wr_claimed_q <= 1'b0;
      alloc_ptr_q  <= '0;
      rd_state_q   <= RIdle;
      rd_slot_q    <= '0;
      rd_off_q     <= '0;
      rd_len_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      cq_wr_q      <= '0;
      cq_rd_q      <= '0;
      buf_wr_q     <= 1'b0;
      buf_rd_q     <= 1'b0;
      buf_cnt_q    <= '0;
      ready_q      <= 1'b0;
      data_ready_q <= 1'b0;
      cur_flags_q  <= '0;
      cur_id_q     <= '0;
      cur_len_q    <= '0;
      dropped_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
      for (int i = 0; i < int'(SLOT_COUNT); i++) begin
        slot_q[i]      <= SlotFree;
        tag_flags_q[i] <= '0;
        tag_id_q[i]    <= '0;
        slot_len_q[i]  <= '0;
        cq_q[i]        <= '0;
      end
    end else begin
      wr_state_q   <= wr_state_d;
      wr_slot_q    <= wr_slot_d;
      wr_len_q     <= wr_len_d;
      wr_claimed_q <= wr_claimed_d;
      rd_state_q   <= rd_state_d;
      rd_slot_q    <= rd_slot_d;
      rd_off_q     <= rd_off_d;
      rd_len_q     <= rd_len_d;
      rd_vld_q     <= rd_issue;
      rd_last_q    <= rd_issue_last;
      for (int i = 0; i < int'(SLOT_COUNT); i++) slot_q[i] <= slot_d[i];
      if (claim) begin
        alloc_ptr_q           <= free_idx + SW'(1);
        tag_flags_q[free_idx] <= ipv4_flags;
        tag_id_q[free_idx]    <= ipv4_identification;
      end
      if (commit) begin
        slot_len_q[commit_idx]  <= commit_len;
        cq_q[cq_wr_q[SW-1:0]]   <= commit_idx;
        cq_wr_q                 <= cq_wr_q + (SW+1)'(1);
      end
      if (rd_start) cq_rd_q <= cq_rd_q + (SW+1)'(1);
      if (rd_vld_q) begin
        buf_data_q[buf_wr_q] <= mem_rdata_q;
        buf_last_q[buf_wr_q] <= rd_last_q;
        buf_wr_q             <= ~buf_wr_q;
      end
      if (pop) buf_rd_q <= ~buf_rd_q;
      buf_cnt_q    <= buf_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
      ready_q      <= any_free;
      data_ready_q <= any_busy;
      cur_flags_q  <= head_valid ? tag_flags_q[head_sel] : '0;
      cur_id_q     <= head_valid ? tag_id_q[head_sel] : '0;
      cur_len_q    <= head_valid ? slot_len_q[head_sel] : '0;
      if (drop && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign ready                       = ready_q;
  assign data_ready                  = data_ready_q;
  assign current_ipv4_flags          = cur_flags_q;
  assign current_ipv4_identification = cur_id_q;
  assign current_length              = cur_len_q;
  assign push_data                   = buf_data_q[buf_rd_q];
  assign push_data_valid             = (buf_cnt_q != 2'd0);
  assign push_data_last              = push_data_valid && buf_last_q[buf_rd_q];
  assign dropped_count               = dropped_q;

endmodule

// File: tb/tb_receive_slot_array.sv
// Directed bench for receive_slot_array: fill, commit, drop, drain ordering, backpressure, reset.
module tb_receive_slot_array;

  localparam int unsigned DW = 8;
  localparam int unsigned SC = 4;
  localparam int unsigned SD = 1024;
  localparam int unsigned LW = $clog2(SD) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data = '0;
  logic          data_enable = 1'b0, good_packet = 1'b0, bad_packet = 1'b0;
  logic [15:0]   ipv4_flags = '0, ipv4_identification = '0;
  logic          push_data_ready = 1'b0;
  logic          ready, data_ready, push_data_valid, push_data_last;
  logic [15:0]   current_ipv4_flags, current_ipv4_identification, dropped_count;
  logic [LW-1:0] current_length;
  logic [DW-1:0] push_data;

  int checks = 0;
  int errors = 0;

  logic [8:0]  rx_q[$];
  logic [31:0] len_q[$], id_q[$], fl_q[$];
  logic        sop = 1'b1;
  logic        hold_pend = 1'b0;
  logic [9:0]  hold_val = '0;

  receive_slot_array #(.DATA_WIDTH(DW), .SLOT_COUNT(SC), .SLOT_DEPTH(SD)) dut (
    .clock                       (clock),
    .reset                       (reset),
    .data                        (data),
    .data_enable                 (data_enable),
    .good_packet                 (good_packet),
    .bad_packet                  (bad_packet),
    .ipv4_flags                  (ipv4_flags),
    .ipv4_identification         (ipv4_identification),
    .push_data_ready             (push_data_ready),
    .ready                       (ready),
    .data_ready                  (data_ready),
    .current_ipv4_flags          (current_ipv4_flags),
    .current_ipv4_identification (current_ipv4_identification),
    .current_length              (current_length),
    .push_data                   (push_data),
    .push_data_valid             (push_data_valid),
    .push_data_last              (push_data_last),
    .dropped_count               (dropped_count)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after the rising edge, so the falling edge sees what the next
  // rising edge will sample.
  always @(negedge clock) begin
    if (reset) begin
      sop       = 1'b1;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        assert ({push_data_valid, push_data_last, push_data} === hold_val)
        else begin
          errors++;
          $error("FAIL hold observed=%0h expected=%0h",
                 {push_data_valid, push_data_last, push_data}, hold_val);
        end
      end
      if (push_data_valid && push_data_ready) begin
        rx_q.push_back({push_data_last, push_data});
        if (sop) begin
          len_q.push_back(32'(current_length));
          id_q.push_back(32'(current_ipv4_identification));
          fl_q.push_back(32'(current_ipv4_flags));
        end
        sop = push_data_last;
      end
      hold_pend = push_data_valid && !push_data_ready;
      hold_val  = {push_data_valid, push_data_last, push_data};
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int n, input logic [7:0] base, input logic [15:0] id,
                      input logic [15:0] fl, input bit is_bad, input bit sep);
    for (int i = 0; i < n; i++) begin
      step();
      data_enable = 1'b1;
      data        = 8'(base + i);
      ipv4_identification = (i == 0) ? id : 16'hFFFF;
      ipv4_flags          = (i == 0) ? fl : 16'hFFFF;
      if (i == n - 1 && !sep) begin
        good_packet = !is_bad;
        bad_packet  = is_bad;
      end
    end
    if (sep) begin
      step();
      data_enable = 1'b0;
      good_packet = !is_bad;
      bad_packet  = is_bad;
    end
    step();
    data_enable = 1'b0;
    good_packet = 1'b0;
    bad_packet  = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic check_pkt(input string tag, input int n, input logic [7:0] base,
                           input logic [15:0] id, input logic [15:0] fl);
    int got = 0;
    int bad_beats = 0;
    logic [8:0] b;
    while (rx_q.size() > 0) begin
      b = rx_q.pop_front();
      if (b[7:0] !== 8'(base + got)) bad_beats++;
      got++;
      if (b[8]) break;
    end
    chk({tag, ".beats"}, 32'(got), 32'(n));
    chk({tag, ".data"}, 32'(bad_beats), 32'd0);
    chk({tag, ".cur_len"}, (len_q.size() > 0) ? len_q.pop_front() : 32'hDEAD, 32'(n));
    chk({tag, ".cur_id"}, (id_q.size() > 0) ? id_q.pop_front() : 32'hDEAD, 32'(id));
    chk({tag, ".cur_flags"}, (fl_q.size() > 0) ? fl_q.pop_front() : 32'hDEAD, 32'(fl));
  endtask

  initial begin
    int k;
    // Reset state
    step(); step(); step();
    chk("rst.valid", 32'(push_data_valid), 32'd0);
    chk("rst.ready", 32'(ready), 32'd0);
    chk("rst.data_ready", 32'(data_ready), 32'd0);
    chk("rst.dropped", 32'(dropped_count), 32'd0);
    reset = 1'b0;
    step();
    chk("init.ready", 32'(ready), 32'd1);
    chk("init.data_ready", 32'(data_ready), 32'd0);

    // T1: 64-beat packet, good on last beat, first beat within 2 cycles of commit
    push_data_ready = 1'b1;
    send(64, 8'h00, 16'h1234, 16'h4000, 1'b0, 1'b0);
    k = 0;
    while (!push_data_valid && k < 2) begin
      step();
      k++;
    end
    chk("t1.latency", 32'(push_data_valid), 32'd1);
    chk("t1.data_ready", 32'(data_ready), 32'd1);
    wait_rx("t1.wait", 64, 80);
    check_pkt("t1", 64, 8'h00, 16'h1234, 16'h4000);

    // Good pulse with no beats in idle is ignored
    step();
    good_packet = 1'b1;
    step();
    good_packet = 1'b0;
    step(); step(); step();
    chk("zero.dropped", 32'(dropped_count), 32'd0);
    chk("zero.data_ready", 32'(data_ready), 32'd0);
    chk("zero.rx", 32'(rx_q.size()), 32'd0);

    // T2: three packets held back, then drained in commit order
    push_data_ready = 1'b0;
    send(10, 8'h10, 16'hA001, 16'h0001, 1'b0, 1'b1);
    send(20, 8'h40, 16'hA002, 16'h0002, 1'b0, 1'b1);
    send(30, 8'h80, 16'hA003, 16'h0003, 1'b0, 1'b1);
    step();
    chk("t2.len_head", 32'(current_length), 32'd10);
    push_data_ready = 1'b1;
    wait_rx("t2.wait", 60, 80);
    check_pkt("t2a", 10, 8'h10, 16'hA001, 16'h0001);
    check_pkt("t2b", 20, 8'h40, 16'hA002, 16'h0002);
    check_pkt("t2c", 30, 8'h80, 16'hA003, 16'h0003);

    // T3: bad packet discarded silently
    send(16, 8'h00, 16'hBBBB, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step();
    chk("t3.rx", 32'(rx_q.size()), 32'd0);
    chk("t3.ready", 32'(ready), 32'd1);
    chk("t3.dropped", 32'(dropped_count), 32'd0);
    send(5, 8'hC0, 16'h0C0C, 16'h2000, 1'b0, 1'b0);
    wait_rx("t3.wait", 5, 20);
    check_pkt("t3", 5, 8'hC0, 16'h0C0C, 16'h2000);

    // T4: overflow by 5 beats
    send(SD + 5, 8'h00, 16'hDDDD, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step();
    chk("t4.rx", 32'(rx_q.size()), 32'd0);
    chk("t4.dropped", 32'(dropped_count), 32'd1);
    chk("t4.ready", 32'(ready), 32'd1);
    chk("t4.data_ready", 32'(data_ready), 32'd0);

    // T5: all slots full, the fifth packet is dropped
    push_data_ready = 1'b0;
    send(5, 8'h20, 16'h0501, 16'h0011, 1'b0, 1'b0);
    send(6, 8'h30, 16'h0502, 16'h0012, 1'b0, 1'b1);
    send(7, 8'h40, 16'h0503, 16'h0013, 1'b0, 1'b0);
    send(8, 8'h50, 16'h0504, 16'h0014, 1'b0, 1'b1);
    step(); step();
    chk("t5.full_ready", 32'(ready), 32'd0);
    chk("t5.data_ready", 32'(data_ready), 32'd1);
    send(4, 8'h60, 16'h0505, 16'h0015, 1'b0, 1'b0);
    step();
    chk("t5.dropped", 32'(dropped_count), 32'd2);
    push_data_ready = 1'b1;
    wait_rx("t5.wait", 26, 60);
    check_pkt("t5a", 5, 8'h20, 16'h0501, 16'h0011);
    check_pkt("t5b", 6, 8'h30, 16'h0502, 16'h0012);
    check_pkt("t5c", 7, 8'h40, 16'h0503, 16'h0013);
    check_pkt("t5d", 8, 8'h50, 16'h0504, 16'h0014);
    step(); step();
    chk("t5.rx_empty", 32'(rx_q.size()), 32'd0);

    // T6: two packets drained under random backpressure, then reset mid-drain
    push_data_ready = 1'b0;
    send(12, 8'h80, 16'h0601, 16'h0021, 1'b0, 1'b0);
    send(9, 8'hA0, 16'h0602, 16'h0022, 1'b0, 1'b1);
    k = 0;
    while (rx_q.size() < 21 && k < 200) begin
      step();
      push_data_ready = 1'($urandom_range(0, 1));
      k++;
    end
    chk("t6.wait", 32'(rx_q.size()), 32'd21);
    check_pkt("t6a", 12, 8'h80, 16'h0601, 16'h0021);
    check_pkt("t6b", 9, 8'hA0, 16'h0602, 16'h0022);
    push_data_ready = 1'b1;
    send(40, 8'h00, 16'h0603, 16'h0023, 1'b0, 1'b0);
    wait_rx("t6.mid", 5, 20);
    reset = 1'b1;
    step();
    chk("t6.rst_valid", 32'(push_data_valid), 32'd0);
    chk("t6.rst_data", 32'(push_data), 32'd0);
    chk("t6.rst_last", 32'(push_data_last), 32'd0);
    chk("t6.rst_ready", 32'(ready), 32'd0);
    chk("t6.rst_data_ready", 32'(data_ready), 32'd0);
    chk("t6.rst_len", 32'(current_length), 32'd0);
    chk("t6.rst_id", 32'(current_ipv4_identification), 32'd0);
    chk("t6.rst_dropped", 32'(dropped_count), 32'd0);
    reset = 1'b0;
    rx_q.delete();
    len_q.delete();
    id_q.delete();
    fl_q.delete();
    step();
    chk("t6.post_ready", 32'(ready), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("t6.post_rx", 32'(rx_q.size()), 32'd0);
    send(3, 8'h10, 16'h0BAD, 16'h0031, 1'b0, 1'b1);
    wait_rx("t6.after", 3, 20);
    check_pkt("t6c", 3, 8'h10, 16'h0BAD, 16'h0031);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
